// File: rtl/neural_layer_engine.sv
// neural_layer_engine
//   Walks a layer-size program held in an instruction ROM and evaluates each
//   layer as a series of dot products. Neuron values ping-pong between two
//   banks of an external dual-port RAM. Weights come from a sync-read ROM and
//   are consumed sequentially across the whole program. Each neuron result is
//   arithmetically right-shifted by FRAC_BITS and saturated to DATA_W bits.
//   Optional macro NLE_RELU_EN clamps negative neuron outputs to zero.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               start pulse (honoured only in IDLE)
//   o_busy/o_done/o_err   handshake; o_err sticky until next accepted start
//   o_instr_addr/i_instr_data    instruction ROM (1-cycle read latency)
//   o_weight_addr/i_weight_data  weight ROM (1-cycle read latency)
//   o_nrd_addr/i_nrd_data        neuron RAM read port (1-cycle read latency)
//   o_nwr_addr/o_nwr_data/o_nwr_en  neuron RAM write port
//   o_result_base/o_result_count    location and size of the final layer
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for i_start
// S_FETCH  | instruction address presented, data arrives next cycle
// S_DECODE | act on the instruction (input size, layer size, end, error)
// S_MAC    | issue one operand pair per cycle, accumulate previous pair
// S_DRAIN  | accumulate the last operand pair of the neuron
// S_WRITE  | write the saturated neuron value, pick next neuron or layer
// S_DONE   | one-cycle completion pulse
module neural_layer_engine #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int ADDR_W     = 8,
    parameter int SIZE_W     = 8,
    parameter int FRAC_BITS  = 0,
    parameter int BANK0_BASE = 0,
    parameter int BANK1_BASE = 20,
    parameter logic [SIZE_W-1:0] END_CODE = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_instr_addr,
    input  logic [SIZE_W-1:0] i_instr_data,
    output logic [ADDR_W-1:0] o_weight_addr,
    input  logic [DATA_W-1:0] i_weight_data,
    output logic [ADDR_W-1:0] o_nrd_addr,
    input  logic [DATA_W-1:0] i_nrd_data,
    output logic [ADDR_W-1:0] o_nwr_addr,
    output logic [DATA_W-1:0] o_nwr_data,
    output logic              o_nwr_en,
    output logic [ADDR_W-1:0] o_result_base,
    output logic [SIZE_W-1:0] o_result_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MAC, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);
    localparam logic [ADDR_W-1:0] B0       = ADDR_W'(BANK0_BASE);
    localparam logic [ADDR_W-1:0] B1       = ADDR_W'(BANK1_BASE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_ip, r_wt_addr, r_nrd_addr, r_nwr_addr;
    logic [ADDR_W-1:0] r_rd_base, r_wr_base, r_res_base;
    logic [SIZE_W-1:0] r_nprev, r_ncur, r_nleft, r_cnt, r_res_count;
    logic              r_first, r_err;
    logic signed [ACC_W-1:0] r_acc;

    logic w_busy, w_done, w_nwr_en, w_set_err;
    logic w_is_end, w_is_zero, w_ip_zero;
    logic signed [ACC_W-1:0] w_wt_ext, w_x_ext, w_prod, w_shift;
    logic signed [DATA_W-1:0] w_sat, w_out;

    assign w_is_end  = (i_instr_data == END_CODE);
    assign w_is_zero = (i_instr_data == '0);
    assign w_ip_zero = (r_ip == '0);

    // Operands are sign-extended to ACC_W first so the product is full precision.
    assign w_wt_ext = ACC_W'($signed(i_weight_data));
    assign w_x_ext  = ACC_W'($signed(i_nrd_data));
    assign w_prod   = w_wt_ext * w_x_ext;
    assign w_shift  = r_acc >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX)
            w_sat = SAT_MAX[DATA_W-1:0];
        else if (w_shift < SAT_MIN)
            w_sat = SAT_MIN[DATA_W-1:0];
    end

`ifdef NLE_RELU_EN
    assign w_out = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign w_out = w_sat;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_nwr_en  = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                w_busy = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_busy = 1'b1;
                if (w_ip_zero) begin
                    // An empty program (END as the input size) is also an error.
                    if (w_is_zero || w_is_end) begin
                        w_set_err = 1'b1;
                        w_next    = S_DONE;
                    end else begin
                        w_next = S_FETCH;
                    end
                end else if (w_is_end) begin
                    w_next = S_DONE;
                end else if (w_is_zero) begin
                    w_set_err = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                w_busy   = 1'b1;
                w_nwr_en = 1'b1;
                w_next   = (r_nleft == '0) ? S_FETCH : S_MAC;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ip        <= '0;
            r_wt_addr   <= '0;
            r_nrd_addr  <= '0;
            r_nwr_addr  <= '0;
            r_rd_base   <= B0;
            r_wr_base   <= B1;
            r_res_base  <= '0;
            r_nprev     <= '0;
            r_ncur      <= '0;
            r_nleft     <= '0;
            r_cnt       <= '0;
            r_res_count <= '0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ip      <= '0;
                        r_wt_addr <= '0;
                        r_err     <= 1'b0;
                        r_nprev   <= '0;
                        r_acc     <= '0;
                        r_rd_base <= B0;
                        r_wr_base <= B1;
                    end
                end
                S_DECODE: begin
                    if (w_set_err) r_err <= 1'b1;
                    if (w_next == S_DONE) begin
                        r_res_base  <= r_rd_base;
                        r_res_count <= r_nprev;
                    end else if (w_ip_zero) begin
                        r_nprev <= i_instr_data;
                        r_ip    <= r_ip + ADDR_ONE;
                    end else begin
                        r_ncur     <= i_instr_data;
                        r_nleft    <= i_instr_data - SIZE_ONE;
                        r_cnt      <= r_nprev - SIZE_ONE;
                        r_nrd_addr <= r_rd_base;
                        r_nwr_addr <= r_wr_base;
                        r_first    <= 1'b1;
                    end
                end
                S_MAC: begin
                    // Read data lags the address by one cycle, so the first
                    // MAC cycle has nothing to accumulate yet.
                    if (!r_first) r_acc <= r_acc + w_prod;
                    r_first    <= 1'b0;
                    r_wt_addr  <= r_wt_addr + ADDR_ONE;
                    r_nrd_addr <= r_nrd_addr + ADDR_ONE;
                    r_cnt      <= r_cnt - SIZE_ONE;
                end
                S_DRAIN:  r_acc <= r_acc + w_prod;
                S_WRITE: begin
                    r_acc <= '0;
                    if (r_nleft == '0) begin
                        r_nprev   <= r_ncur;
                        r_rd_base <= r_wr_base;
                        r_wr_base <= r_rd_base;
                        r_ip      <= r_ip + ADDR_ONE;
                    end else begin
                        r_nleft    <= r_nleft - SIZE_ONE;
                        r_nwr_addr <= r_nwr_addr + ADDR_ONE;
                        r_cnt      <= r_nprev - SIZE_ONE;
                        r_nrd_addr <= r_rd_base;
                        r_first    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = w_busy;
    assign o_done         = w_done;
    assign o_err          = r_err;
    assign o_instr_addr   = r_ip;
    assign o_weight_addr  = r_wt_addr;
    assign o_nrd_addr     = r_nrd_addr;
    assign o_nwr_addr     = r_nwr_addr;
    assign o_nwr_data     = w_out;
    assign o_nwr_en       = w_nwr_en;
    assign o_result_base  = r_res_base;
    assign o_result_count = r_res_count;

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed bench for neural_layer_engine with behavioural sync-read memories.
// Honours NLE_RELU_EN for the expected values of negative results.
module tb_neural_layer_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, err, nwr_en;
    logic [7:0] instr_addr, instr_data, weight_addr, weight_data;
    logic [7:0] nrd_addr, nrd_data, nwr_addr, nwr_data;
    logic [7:0] result_base, result_count;

    neural_layer_engine dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_instr_addr   (instr_addr),
        .i_instr_data   (instr_data),
        .o_weight_addr  (weight_addr),
        .i_weight_data  (weight_data),
        .o_nrd_addr     (nrd_addr),
        .i_nrd_data     (nrd_data),
        .o_nwr_addr     (nwr_addr),
        .o_nwr_data     (nwr_data),
        .o_nwr_en       (nwr_en),
        .o_result_base  (result_base),
        .o_result_count (result_count)
    );

    always #5 clk = ~clk;

    logic [7:0] instr_mem [256];
    logic [7:0] wt_mem    [256];
    logic [7:0] nram      [256];
    logic [7:0] x_init    [4];
    logic       tb_load = 1'b0;

    always @(posedge clk) begin
        instr_data  <= instr_mem[instr_addr];
        weight_data <= wt_mem[weight_addr];
        nrd_data    <= nram[nrd_addr];
        if (tb_load) begin
            for (int i = 0; i < 4; i++) nram[i] <= x_init[i];
        end else if (nwr_en) begin
            nram[nwr_addr] <= nwr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wa_log [64];
    logic [7:0] wd_log [64];
    int         wc_log [64];
    int         n_wr = 0;
    always @(negedge clk) begin
        if (nwr_en && n_wr < 64) begin
            wa_log[n_wr] = nwr_addr;
            wd_log[n_wr] = nwr_data;
            wc_log[n_wr] = cyc;
            n_wr = n_wr + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_prog(input logic [7:0] a, b, c, d);
        instr_mem[0] = a;
        instr_mem[1] = b;
        instr_mem[2] = c;
        instr_mem[3] = d;
    endtask

    task automatic set_w(input int base, input logic [7:0] a, b, c, d);
        wt_mem[base]   = a;
        wt_mem[base+1] = b;
        wt_mem[base+2] = c;
        wt_mem[base+3] = d;
    endtask

    task automatic set_x(input logic [7:0] a, b, c, d);
        x_init[0] = a;
        x_init[1] = b;
        x_init[2] = c;
        x_init[3] = d;
        @(negedge clk) tb_load = 1'b1;
        @(negedge clk) tb_load = 1'b0;
    endtask

    int         start_cyc, wr0;
    logic       got_done;
    logic [7:0] d_err, d_base, d_count, d_waddr;

    task automatic run_prog(input string tag);
        got_done = 1'b0;
        wr0      = n_wr;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        start = 1'b0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                d_err    = {7'd0, err};
                d_base   = result_base;
                d_count  = result_count;
                d_waddr  = weight_addr;
            end
        end
        if (!got_done) check_eq({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    function automatic logic [7:0] wa_at(input int i);
        return (i < n_wr) ? wa_log[i] : 8'hEE;
    endfunction
    function automatic logic [7:0] wd_at(input int i);
        return (i < n_wr) ? wd_log[i] : 8'hEE;
    endfunction

    logic [7:0] exp_neg128, exp_fe;

    initial begin
`ifdef NLE_RELU_EN
        exp_neg128 = 8'h00;
        exp_fe     = 8'h00;
`else
        exp_neg128 = 8'h80;
        exp_fe     = 8'hFE;
`endif
        for (int i = 0; i < 256; i++) begin
            instr_mem[i] = 8'hFF;
            wt_mem[i]    = 8'h00;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_nwr_en", nwr_en, 0);
        check_eq("rst_addrs", {instr_addr, weight_addr, nrd_addr, nwr_addr}, 0);
        check_eq("rst_result", {result_base, result_count}, 0);
        reset = 1'b0;

        // Basic dot product 3*2 + 4*5 = 26
        set_prog(8'd2, 8'd1, 8'hFF, 8'hFF);
        set_w(0, 8'd2, 8'd5, 8'd0, 8'd0);
        set_x(8'd3, 8'd4, 8'd0, 8'd0);
        run_prog("basic");
        check_eq("basic_nwr", n_wr - wr0, 1);
        check_eq("basic_addr", wa_at(wr0), 20);
        check_eq("basic_data", wd_at(wr0), 26);
        // FETCH,DECODE,FETCH,DECODE then Nprev+2 cycles ending in WRITE
        check_eq("basic_latency", wc_log[wr0] - start_cyc, 2 + 5);
        check_eq("basic_err", d_err, 0);
        check_eq("basic_base", d_base, 20);
        check_eq("basic_count", d_count, 1);
        check_eq("basic_busy_after", busy, 0);

        // Two neurons: spacing between writes is Nprev+2
        set_prog(8'd2, 8'd2, 8'hFF, 8'hFF);
        set_w(0, 8'd2, 8'd5, 8'hFF, 8'd1);
        set_x(8'd3, 8'd4, 8'd0, 8'd0);
        run_prog("two");
        check_eq("two_nwr", n_wr - wr0, 2);
        check_eq("two_d0", wd_at(wr0), 26);
        check_eq("two_a1", wa_at(wr0 + 1), 21);
        check_eq("two_d1", wd_at(wr0 + 1), 1);
        check_eq("two_spacing", wc_log[wr0 + 1] - wc_log[wr0], 4);

        // Positive saturation
        set_prog(8'd2, 8'd1, 8'hFF, 8'hFF);
        set_w(0, 8'd100, 8'd100, 8'd0, 8'd0);
        set_x(8'd100, 8'd100, 8'd0, 8'd0);
        run_prog("satp");
        check_eq("satp_data", wd_at(wr0), 8'd127);

        // Negative saturation
        set_w(0, 8'h9C, 8'h9C, 8'd0, 8'd0);
        run_prog("satn");
        check_eq("satn_data", wd_at(wr0), exp_neg128);

        // Small negative: -6 + 4 = -2
        set_w(0, 8'hFE, 8'd1, 8'd0, 8'd0);
        set_x(8'd3, 8'd4, 8'd0, 8'd0);
        run_prog("neg");
        check_eq("neg_data", wd_at(wr0), exp_fe);

        // Ping-pong across three layers of size 1
        set_prog(8'd1, 8'd1, 8'd1, 8'hFF);
        set_w(0, 8'd2, 8'd3, 8'd0, 8'd0);
        set_x(8'd5, 8'd0, 8'd0, 8'd0);
        run_prog("pp");
        check_eq("pp_nwr", n_wr - wr0, 2);
        check_eq("pp_w0", {wa_at(wr0), wd_at(wr0)}, {8'd20, 8'd10});
        check_eq("pp_w1", {wa_at(wr0 + 1), wd_at(wr0 + 1)}, {8'd0, 8'd30});
        check_eq("pp_base", d_base, 0);
        check_eq("pp_count", d_count, 1);
        check_eq("pp_waddr", d_waddr, 2);

        // Start together with reset is ignored
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rststart_busy", busy, 0);

        // Reset during MAC abandons the layer
        set_prog(8'd4, 8'd2, 8'hFF, 8'hFF);
        set_w(0, 8'd1, 8'd1, 8'd1, 8'd1);
        set_w(4, 8'd2, 8'd0, 8'd0, 8'd1);
        set_x(8'd1, 8'd2, 8'd3, 8'd4);
        wr0 = n_wr;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("midrst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", busy, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midrst_no_write", n_wr - wr0, 0);
        run_prog("restart");
        check_eq("restart_nwr", n_wr - wr0, 2);
        check_eq("restart_w0", {wa_at(wr0), wd_at(wr0)}, {8'd20, 8'd10});
        check_eq("restart_w1", {wa_at(wr0 + 1), wd_at(wr0 + 1)}, {8'd21, 8'd6});
        check_eq("restart_count", d_count, 2);

        // Zero-size layer
        set_prog(8'd2, 8'd0, 8'd1, 8'hFF);
        run_prog("zero");
        check_eq("zero_err", d_err, 1);
        check_eq("zero_nwr", n_wr - wr0, 0);
        check_eq("zero_err_sticky", err, 1);

        // Empty program
        set_prog(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_prog("empty");
        check_eq("empty_err", d_err, 1);

        // Input layer only
        set_prog(8'd2, 8'hFF, 8'hFF, 8'hFF);
        run_prog("inonly");
        check_eq("inonly_err", d_err, 0);
        check_eq("inonly_base", d_base, 0);
        check_eq("inonly_count", d_count, 2);
        check_eq("inonly_nwr", n_wr - wr0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
